// File: rtl/blake2_io_tx.sv
// Host-side byte-serial transmitter for the BLAKE2s command interface.
// Sends the 10-byte CONF sequence, then padded 64-byte blocks tagged START/DATA/LAST.
// Ports: clk, nreset (async low); job: start_i, kk_i, nn_i, ll_i;
//   upstream: s_valid_i, s_data_i, s_ready_o; hasher: dev_ready_i, valid_o, cmd_o, data_o;
//   status: busy_o, done_o, err_o.
// Optional: define BLAKE2_IO_TX_CHECK_EN to reject jobs with nn=0, nn>32 or kk>32.
module blake2_io_tx (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    input  logic        dev_ready_i,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONF,
        S_WAIT,
        S_BLOCK
    } state_t;

    state_t      state;
    state_t      next;
    logic [5:0]  nn_q;
    logic [3:0]  conf_idx;
    logic [5:0]  byte_idx;
    logic [5:0]  key_rem;
    logic [63:0] msg_rem;
    logic [6:0]  blk_cnt;
    logic        key_blk;
    logic        first_blk;
    logic        last_blk;
    logic        done_pend;

    logic        is_stream;
    logic        advance;
    logic        blk_end;
    logic        start_bad;
    logic        start_ok;
    logic [1:0]  blk_cmd;
    logic [2:0]  lsel;
    logic [7:0]  conf_byte;
    logic        valid_d;
    logic [1:0]  cmd_d;
    logic [7:0]  data_d;
    logic        err_d;

`ifdef BLAKE2_IO_TX_CHECK_EN
    assign start_bad = (nn_i == 6'd0) || (nn_i > 6'd32) || (kk_i > 6'd32);
`else
    assign start_bad = 1'b0;
`endif

    assign start_ok = (state == S_IDLE) && start_i && !start_bad;

    // Key bytes are counted down directly; message bytes use the per-block
    // stream length latched when the block starts.
    assign is_stream = key_blk ? (key_rem != 6'd0)
                               : ({1'b0, byte_idx} < blk_cnt);
    assign s_ready_o = (state == S_BLOCK) && is_stream;
    assign advance   = (state == S_BLOCK) && (!is_stream || s_valid_i);
    assign blk_end   = advance && (byte_idx == 6'd63);
    assign busy_o    = (state != S_IDLE);

    // The length bytes are read from the message counter, which does not
    // move until the first block starts.
    assign lsel = 3'(conf_idx - 4'd2);

    always_comb begin
        conf_byte = msg_rem[{lsel, 3'b000} +: 8];
        if (conf_idx == 4'd1) begin
            conf_byte = {2'b00, nn_q};
        end
    end

    always_comb begin
        blk_cmd = CMD_DATA;
        if (byte_idx == 6'd0) begin
            if (first_blk) begin
                blk_cmd = CMD_START;
            end else if (last_blk) begin
                blk_cmd = CMD_LAST;
            end
        end else if (byte_idx == 6'd1 && first_blk && last_blk) begin
            blk_cmd = CMD_LAST;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next    = state;
        valid_d = 1'b0;
        cmd_d   = CMD_CONF;
        data_d  = 8'h00;
        err_d   = (state == S_IDLE) && start_i && start_bad;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    next    = S_CONF;
                    valid_d = 1'b1;
                    data_d  = {2'b00, kk_i};
                end
            end
            S_CONF: begin
                valid_d = 1'b1;
                data_d  = conf_byte;
                if (conf_idx == 4'd9) begin
                    next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dev_ready_i) begin
                    next = S_BLOCK;
                end
            end
            S_BLOCK: begin
                if (advance) begin
                    valid_d = 1'b1;
                    cmd_d   = blk_cmd;
                    data_d  = is_stream ? s_data_i : 8'h00;
                end
                if (blk_end) begin
                    next = last_blk ? S_IDLE : S_WAIT;
                end
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nn_q      <= '0;
            conf_idx  <= '0;
            byte_idx  <= '0;
            key_rem   <= '0;
            msg_rem   <= '0;
            blk_cnt   <= '0;
            key_blk   <= 1'b0;
            first_blk <= 1'b0;
            last_blk  <= 1'b0;
        end else begin
            if (start_ok) begin
                nn_q      <= nn_i;
                key_rem   <= kk_i;
                msg_rem   <= ll_i;
                conf_idx  <= 4'd1;
                first_blk <= 1'b1;
            end
            if (state == S_CONF) begin
                conf_idx <= conf_idx + 4'd1;
            end
            if (state == S_WAIT && dev_ready_i) begin
                byte_idx <= '0;
                key_blk  <= (key_rem != 6'd0);
                if (key_rem != 6'd0) begin
                    last_blk <= (msg_rem == 64'd0);
                end else begin
                    last_blk <= (msg_rem <= 64'd64);
                end
                blk_cnt <= (msg_rem >= 64'd64) ? 7'd64 : msg_rem[6:0];
            end
            if (advance) begin
                byte_idx <= byte_idx + 6'd1;
                if (is_stream && key_blk) begin
                    key_rem <= key_rem - 6'd1;
                end
                if (is_stream && !key_blk) begin
                    msg_rem <= msg_rem - 64'd1;
                end
            end
            if (blk_end) begin
                first_blk <= 1'b0;
            end
        end
    end

    // done_o follows the cycle in which the final byte is on data_o.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_o   <= 1'b0;
            cmd_o     <= '0;
            data_o    <= '0;
            err_o     <= 1'b0;
            done_pend <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            valid_o   <= valid_d;
            cmd_o     <= cmd_d;
            data_o    <= data_d;
            err_o     <= err_d;
            done_pend <= blk_end && last_blk;
            done_o    <= done_pend;
        end
    end

endmodule
